// File: rtl/bit_serial_adder.sv
// Bit-serial unsigned adder: one full-adder step per clock, LSB first, with a registered carry loop.
// Define SERIAL_ADD_OVF_EN to add the registered two's-complement overflow output ovf.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // The single 1-bit adder cell: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  state_t             state_r;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   s_sh_r;
  logic               c_reg_r;
  logic [CW-1:0]      cnt_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   sum_out_r;
  logic               cout_r;
  logic               sum_bit_s;
  logic               carry_s;
  logic [WIDTH-1:0]   s_next_s;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_r;
`endif

  // Current adder step and the sum register as it will look after this step.
  always_comb begin
    {carry_s, sum_bit_s} = full_add(a_sh_r[0], b_sh_r[0], c_reg_r);
    s_next_s = {sum_bit_s, s_sh_r[WIDTH-1:1]};
  end

  // Sequencer: capture operands in IDLE, step one bit per clock in SHIFT, publish on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      a_sh_r    <= {WIDTH{1'b0}};
      b_sh_r    <= {WIDTH{1'b0}};
      s_sh_r    <= {WIDTH{1'b0}};
      c_reg_r   <= 1'b0;
      cnt_r     <= CNT_ZERO;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      sum_out_r <= {WIDTH{1'b0}};
      cout_r    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sh_r  <= a_in;
            b_sh_r  <= b_in;
            c_reg_r <= cin;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          s_sh_r  <= s_next_s;
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          c_reg_r <= carry_s;
          if (cnt_r == CNT_LAST) begin
            // c_reg_r is the carry into the MSB here, carry_s the carry out of it.
            sum_out_r <= s_next_s;
            cout_r    <= carry_s;
`ifdef SERIAL_ADD_OVF_EN
            ovf_r     <= c_reg_r ^ carry_s;
`endif
            cnt_r     <= CNT_ZERO;
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end else begin
            cnt_r     <= cnt_r + CNT_ONE;
            done_r    <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= SHIFT;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign sum_out  = sum_out_r;
  assign cout_out = cout_r;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf      = ovf_r;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and randomized self-checking bench for bit_serial_adder at WIDTH=8.
// Checks ovf too when SERIAL_ADD_OVF_EN is defined.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout_out;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start high for exactly one accepted edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts edges until done; busy must stay high before done and drop with it.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done) begin
        lat = i;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    a_in  = 8'h00;
    b_in  = 8'h00;
    cin   = 1'b0;
    #2;
    rst_n = 1'b0;
    step();
    step();
    n_vec++;
    if ({busy, done, sum_out, cout_out} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b expected all 0", busy, done, sum_out, cout_out);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    #2;
    rst_n = 1'b1;
    step();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat;
    bit ok;
    issue(8'h5A, 8'h3C, 1'b0);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_on_accept: got %b expected 1", busy); end
    wait_done(lat, ok);
    n_vec++;
    if (lat !== 8) begin n_err++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL basic_busy_profile: got bad expected busy high until done"); end
    n_vec++;
    if (sum_out !== 8'h96 || cout_out !== 1'b0) begin
      n_err++;
      $display("FAIL basic_sum: got %h/%b expected 96/0", sum_out, cout_out);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_vec++;
    if (ovf !== 1'b1) begin n_err++; $display("FAIL basic_ovf: got %b expected 1", ovf); end
`endif
    step();
    n_vec++;
    if (done !== 1'b0 || sum_out !== 8'h96) begin
      n_err++;
      $display("FAIL basic_done_single_hold: got done=%b sum=%h expected 0/96", done, sum_out);
    end
  endtask

  task automatic test_boundary();
    int lat;
    bit ok;
    issue(8'hFF, 8'h01, 1'b0);
    wait_done(lat, ok);
    n_vec++;
    if (lat !== 8 || sum_out !== 8'h00 || cout_out !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_ff_01: got lat=%0d sum=%h cout=%b expected 8/00/1", lat, sum_out, cout_out);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL wrap_ovf: got %b expected 0", ovf); end
`endif
    issue(8'h00, 8'h00, 1'b1);
    wait_done(lat, ok);
    n_vec++;
    if (lat !== 8 || sum_out !== 8'h01 || cout_out !== 1'b0) begin
      n_err++;
      $display("FAIL cin_only: got lat=%0d sum=%h cout=%b expected 8/01/0", lat, sum_out, cout_out);
    end
  endtask

  task automatic test_ignore_busy();
    int n_done;
    int first_at;
    logic [W-1:0] s_seen;
    logic         c_seen;
    n_done   = 0;
    first_at = -1;
    s_seen   = 8'h00;
    c_seen   = 1'b0;
    issue(8'h12, 8'h34, 1'b0);
    step();
    step();
    a_in  = 8'hFF;
    b_in  = 8'hFF;
    cin   = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 4; i <= 24; i++) begin
      step();
      if (done) begin
        n_done++;
        if (first_at < 0) begin
          first_at = i;
          s_seen   = sum_out;
          c_seen   = cout_out;
        end
      end
    end
    n_vec++;
    if (n_done !== 1) begin n_err++; $display("FAIL busy_start_pulses: got %0d expected 1", n_done); end
    n_vec++;
    if (first_at !== 8) begin n_err++; $display("FAIL busy_start_latency: got %0d expected 8", first_at); end
    n_vec++;
    if (s_seen !== 8'h46 || c_seen !== 1'b0) begin
      n_err++;
      $display("FAIL busy_start_result: got %h/%b expected 46/0", s_seen, c_seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit ok;
    a_in  = 8'h11;
    b_in  = 8'h22;
    cin   = 1'b0;
    start = 1'b1;
    step();
    a_in  = 8'h80;
    b_in  = 8'h80;
    wait_done(lat, ok);
    n_vec++;
    if (lat !== 8 || sum_out !== 8'h33 || cout_out !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first: got lat=%0d sum=%h cout=%b expected 8/33/0", lat, sum_out, cout_out);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL b2b_first_ovf: got %b expected 0", ovf); end
`endif
    step();
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b done=%b expected 1/0", busy, done);
    end
    wait_done(lat, ok);
    n_vec++;
    if (lat !== 8 || !ok || sum_out !== 8'h00 || cout_out !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second: got lat=%0d busy_ok=%b sum=%h cout=%b expected 8/1/00/1", lat, ok, sum_out, cout_out);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_vec++;
    if (ovf !== 1'b1) begin n_err++; $display("FAIL b2b_second_ovf: got %b expected 1", ovf); end
`endif
  endtask

  task automatic test_abort();
    int lat;
    bit ok;
    bit seen_done;
    issue(8'h0F, 8'h10, 1'b0);
    wait_done(lat, ok);
    n_vec++;
    if (sum_out !== 8'h1F) begin n_err++; $display("FAIL abort_pre: got %h expected 1f", sum_out); end
    step();
    issue(8'h55, 8'h55, 1'b1);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || sum_out !== 8'h00 || cout_out !== 1'b0) begin
      n_err++;
      $display("FAIL abort_immediate: got busy=%b done=%b sum=%h cout=%b expected 0/0/00/0", busy, done, sum_out, cout_out);
    end
    step();
    #2;
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done || busy) seen_done = 1'b1;
    end
    n_vec++;
    if (seen_done) begin n_err++; $display("FAIL abort_discarded: got activity expected idle"); end
    issue(8'h01, 8'h02, 1'b0);
    wait_done(lat, ok);
    n_vec++;
    if (lat !== 8 || !ok || sum_out !== 8'h03 || cout_out !== 1'b0) begin
      n_err++;
      $display("FAIL abort_recover: got lat=%0d busy_ok=%b sum=%h cout=%b expected 8/1/03/0", lat, ok, sum_out, cout_out);
    end
  endtask

  task automatic test_random();
    int lat;
    bit ok;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W:0]   ref_sum;
    logic         ref_ovf;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      c = 1'($urandom_range(0, 1));
      ref_sum = {1'b0, a} + {1'b0, b} + {8'h00, c};
      ref_ovf = (a[W-1] == b[W-1]) && (ref_sum[W-1] != a[W-1]);
      issue(a, b, c);
      wait_done(lat, ok);
      n_vec++;
      if (lat !== 8 || !ok) begin
        n_err++;
        $display("FAIL rand_timing[%0d]: got lat=%0d busy_ok=%b expected 8/1", i, lat, ok);
      end
      n_vec++;
      if ({cout_out, sum_out} !== ref_sum) begin
        n_err++;
        $display("FAIL rand_sum[%0d]: got %h expected %h (a=%h b=%h cin=%b)", i, {cout_out, sum_out}, ref_sum, a, b, c);
      end
`ifdef SERIAL_ADD_OVF_EN
      n_vec++;
      if (ovf !== ref_ovf) begin
        n_err++;
        $display("FAIL rand_ovf[%0d]: got %b expected %b", i, ovf, ref_ovf);
      end
`endif
      if (ref_ovf === 1'bx) n_err++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_ignore_busy();
    test_back_to_back();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
